// File: rtl/mem_stage_unit.sv
// Memory-access pipeline stage: holds one EX instruction, waits for the data SRAM on loads,
// and aligns load data. Optional macro ME_LOAD_FWD_EN forwards aligned load data to ID.
module mem_stage_unit #(
    parameter int EX_ME_W = 131,
    parameter int ME_WB_W = 125
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EX_to_ME_Valid,
    input  logic [EX_ME_W-1:0] EX_to_ME_Bus,
    output logic               ME_Allow_in,
    output logic               ME_to_WB_Valid,
    input  logic               WB_Allow_in,
    output logic [ME_WB_W-1:0] ME_to_WB_Bus,
    input  logic [31:0]        data_sram_rdata,
    input  logic               data_sram_data_ok,
    input  logic               excp_flush,
    input  logic               ertn_flush,
    output logic [4:0]         ME_dest,
    output logic [31:0]        ME_Forward_Res,
    output logic               ME_to_ID_Ld_wait,
    output logic               ME_to_EX_Sys_op,
    output logic [46:0]        ME_to_EX_Bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ld_state_e;

    logic               r_valid;
    logic [EX_ME_W-1:0] r_bus;
    ld_state_e          r_state;
    ld_state_e          w_state_nxt;
    logic               r_cancel;
    logic [31:0]        r_rdata_buf;

    // Field view of the latched EX_to_ME bus
    logic        w_excp_en;
    logic [5:0]  w_excp_num;
    logic [13:0] w_csr_num;
    logic        w_csr_we;
    logic [31:0] w_csr_wvalue;
    logic        w_inst_ertn;
    logic [4:0]  w_dest_flag;
    logic [31:0] w_pc;
    logic [31:0] w_result;
    logic        w_res_from_mem;
    logic        w_gr_we;
    logic [4:0]  w_dest;

    assign {w_excp_en, w_excp_num, w_csr_num, w_csr_we, w_csr_wvalue, w_inst_ertn,
            w_dest_flag, w_pc, w_result, w_res_from_mem, w_gr_we, w_dest} = r_bus;

    logic w_flush;
    logic w_accept;
    logic w_need_data;
    logic w_in_need_data;
    logic w_data_hit;
    logic w_ready_go;
    logic w_capture;
    logic w_use_buf;

    assign w_flush        = excp_flush | ertn_flush;
    assign w_need_data    = w_res_from_mem & ~w_excp_en;
    assign w_in_need_data = EX_to_ME_Bus[6] & ~EX_to_ME_Bus[EX_ME_W-1];
    // A data_ok seen while cancel is set belongs to a flushed load and is dropped
    assign w_data_hit     = data_sram_data_ok & ~r_cancel;

    assign ME_Allow_in    = ~r_valid | (w_ready_go & WB_Allow_in);
    assign ME_to_WB_Valid = r_valid & w_ready_go;
    assign w_accept       = ME_Allow_in & EX_to_ME_Valid;

    // Load FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Load FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = w_in_need_data ? S_WAIT : S_IDLE;
        end else begin
            case (r_state)
                S_WAIT: if (w_data_hit) w_state_nxt = WB_Allow_in ? S_IDLE : S_HOLD;
                S_HOLD: if (WB_Allow_in) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Load FSM: outputs
    always_comb begin
        w_ready_go = ~w_need_data;
        w_capture  = 1'b0;
        w_use_buf  = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_ready_go = ~w_need_data | w_data_hit;
                w_capture  = w_data_hit & ~WB_Allow_in;
            end
            S_HOLD: begin
                w_ready_go = 1'b1;
                w_use_buf  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cancel <= 1'b0;
        end else if (w_flush && r_state == S_WAIT && !data_sram_data_ok) begin
            r_cancel <= 1'b1;
        end else if (data_sram_data_ok) begin
            r_cancel <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata_buf <= 32'd0;
        end else if (w_capture) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_valid <= 1'b0;
        end else if (ME_Allow_in) begin
            r_valid <= EX_to_ME_Valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= '0;
        end else if (w_accept) begin
            r_bus <= EX_to_ME_Bus;
        end
    end

    // Load alignment: dest_flag = {signed, byte, half, off[1:0]}
    logic [31:0] w_src;
    logic [31:0] w_shift;
    logic [15:0] w_half;
    logic [31:0] w_aligned;
    logic [31:0] w_final;

    assign w_src   = w_use_buf ? r_rdata_buf : data_sram_rdata;
    assign w_shift = w_src >> {w_dest_flag[1:0], 3'b000};
    assign w_half  = w_dest_flag[1] ? w_src[31:16] : w_src[15:0];

    always_comb begin
        w_aligned = w_src;
        if (w_dest_flag[3]) begin
            w_aligned = {{24{w_dest_flag[4] & w_shift[7]}}, w_shift[7:0]};
        end else if (w_dest_flag[2]) begin
            w_aligned = {{16{w_dest_flag[4] & w_half[15]}}, w_half};
        end
    end

    assign w_final = w_res_from_mem ? w_aligned : w_result;

    assign ME_to_WB_Bus = {w_excp_en, w_excp_num, w_csr_num, w_csr_we, w_csr_wvalue,
                           w_inst_ertn, w_pc, w_final, w_gr_we, w_dest};

    assign ME_dest         = w_dest & {5{r_valid & w_gr_we}};
    assign ME_Forward_Res  = w_final;
    assign ME_to_EX_Sys_op = r_valid & (w_excp_en | w_inst_ertn);
    assign ME_to_EX_Bus    = {w_csr_num, w_csr_we & r_valid & ~w_excp_en, w_csr_wvalue};

`ifdef ME_LOAD_FWD_EN
    assign ME_to_ID_Ld_wait = r_valid & w_res_from_mem & ~w_ready_go;
`else
    // Without load forwarding ID waits until the load has left ME entirely
    assign ME_to_ID_Ld_wait = r_valid & w_res_from_mem;
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Self-checking bench for mem_stage_unit: directed scenarios plus a randomized stream
// scored against a transaction-level expectation queue.
module tb_mem_stage_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         EX_to_ME_Valid;
    logic [130:0] EX_to_ME_Bus;
    logic         ME_Allow_in;
    logic         ME_to_WB_Valid;
    logic         WB_Allow_in;
    logic [124:0] ME_to_WB_Bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_data_ok;
    logic         excp_flush;
    logic         ertn_flush;
    logic [4:0]   ME_dest;
    logic [31:0]  ME_Forward_Res;
    logic         ME_to_ID_Ld_wait;
    logic         ME_to_EX_Sys_op;
    logic [46:0]  ME_to_EX_Bus;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_unit dut (
        .clk(clk), .reset(reset),
        .EX_to_ME_Valid(EX_to_ME_Valid), .EX_to_ME_Bus(EX_to_ME_Bus),
        .ME_Allow_in(ME_Allow_in), .ME_to_WB_Valid(ME_to_WB_Valid),
        .WB_Allow_in(WB_Allow_in), .ME_to_WB_Bus(ME_to_WB_Bus),
        .data_sram_rdata(data_sram_rdata), .data_sram_data_ok(data_sram_data_ok),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .ME_dest(ME_dest), .ME_Forward_Res(ME_Forward_Res),
        .ME_to_ID_Ld_wait(ME_to_ID_Ld_wait), .ME_to_EX_Sys_op(ME_to_EX_Sys_op),
        .ME_to_EX_Bus(ME_to_EX_Bus)
    );

    function automatic logic [130:0] mk_bus(
        input logic excp_en, input logic [5:0] excp_num, input logic [13:0] csr_num,
        input logic csr_we, input logic [31:0] csr_wv, input logic ertn,
        input logic [4:0] flag, input logic [31:0] pc, input logic [31:0] res,
        input logic rfm, input logic gw, input logic [4:0] dest);
        return {excp_en, excp_num, csr_num, csr_we, csr_wv, ertn, flag, pc, res, rfm, gw, dest};
    endfunction

    // Reference load extraction written arithmetically from the flag meaning
    function automatic logic [31:0] align_ref(input logic [31:0] d, input logic [4:0] f);
        logic [31:0] v;
        int unsigned sh;
        sh = 8 * int'(f[1:0]);
        if (f[3]) begin
            v = (d >> sh) & 32'hFF;
            if (f[4] && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f[2]) begin
            v = f[1] ? (d >> 16) : (d & 32'hFFFF);
            if (f[4] && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        EX_to_ME_Valid    = 1'b0;
        EX_to_ME_Bus      = '0;
        WB_Allow_in       = 1'b1;
        data_sram_rdata   = 32'h0;
        data_sram_data_ok = 1'b0;
        excp_flush        = 1'b0;
        ertn_flush        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        #2;
        total++; if (ME_Allow_in !== 1'b1) begin bad++; $display("FAIL reset_allow_in got=%b exp=1", ME_Allow_in); end
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", ME_to_WB_Valid); end
        total++; if (ME_dest !== 5'd0) begin bad++; $display("FAIL reset_dest got=%h exp=0", ME_dest); end
        total++; if (ME_to_ID_Ld_wait !== 1'b0) begin bad++; $display("FAIL reset_ldwait got=%b exp=0", ME_to_ID_Ld_wait); end
        total++; if (ME_to_EX_Sys_op !== 1'b0) begin bad++; $display("FAIL reset_sysop got=%b exp=0", ME_to_EX_Sys_op); end
        total++; if (ME_to_EX_Bus[32] !== 1'b0) begin bad++; $display("FAIL reset_csr_we got=%b exp=0", ME_to_EX_Bus[32]); end
        step();
    endtask

    task automatic test_alu();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 0, 0, 0, 0, 5'd0, 32'h1C00_0000, 32'h1234, 0, 1, 5'd5);
        WB_Allow_in    = 1'b1;
        step();
        EX_to_ME_Valid = 1'b0;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", ME_to_WB_Valid); end
        total++; if (ME_to_WB_Bus[37:6] !== 32'h1234) begin bad++; $display("FAIL alu_result got=%h exp=00001234", ME_to_WB_Bus[37:6]); end
        total++; if (ME_dest !== 5'd5) begin bad++; $display("FAIL alu_dest got=%0d exp=5", ME_dest); end
        total++; if (ME_Forward_Res !== 32'h1234) begin bad++; $display("FAIL alu_fwd got=%h exp=00001234", ME_Forward_Res); end
        step();
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL alu_drain got=%b exp=0", ME_to_WB_Valid); end
        step();
    endtask

    task automatic test_load_byte();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 0, 0, 0, 0, 5'b11011, 32'h100, 32'h0, 1, 1, 5'd7);
        step();
        EX_to_ME_Valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL ldb_wait_valid cyc=%0d got=%b exp=0", c, ME_to_WB_Valid); end
            total++; if (ME_to_ID_Ld_wait !== 1'b1) begin bad++; $display("FAIL ldb_ldwait cyc=%0d got=%b exp=1", c, ME_to_ID_Ld_wait); end
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b1) begin bad++; $display("FAIL ldb_valid got=%b exp=1", ME_to_WB_Valid); end
        total++; if (ME_to_WB_Bus[37:6] !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldb_result got=%h exp=ffffff80", ME_to_WB_Bus[37:6]); end
`ifdef ME_LOAD_FWD_EN
        total++; if (ME_to_ID_Ld_wait !== 1'b0) begin bad++; $display("FAIL ldb_ldwait_ok got=%b exp=0", ME_to_ID_Ld_wait); end
        total++; if (ME_Forward_Res !== 32'hFFFF_FF80) begin bad++; $display("FAIL ldb_fwd got=%h exp=ffffff80", ME_Forward_Res); end
`else
        total++; if (ME_to_ID_Ld_wait !== 1'b1) begin bad++; $display("FAIL ldb_ldwait_ok got=%b exp=1", ME_to_ID_Ld_wait); end
`endif
        step();
        data_sram_data_ok = 1'b0;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL ldb_drain got=%b exp=0", ME_to_WB_Valid); end
        step();
    endtask

    task automatic test_load_hold();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 0, 0, 0, 0, 5'b00110, 32'h200, 32'h0, 1, 1, 5'd9);
        step();
        EX_to_ME_Valid    = 1'b0;
        WB_Allow_in       = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_1234;
        #2;
        total++; if (ME_Allow_in !== 1'b0) begin bad++; $display("FAIL hold_allow got=%b exp=0", ME_Allow_in); end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            #2;
            total++; if (ME_to_WB_Valid !== 1'b1 || ME_to_WB_Bus[37:6] !== 32'h0000_BEEF) begin
                bad++; $display("FAIL hold_stall cyc=%0d got=%b/%h exp=1/0000beef", c, ME_to_WB_Valid, ME_to_WB_Bus[37:6]); end
            step();
        end
        WB_Allow_in = 1'b1;
        #2;
        total++; if (ME_to_WB_Bus[37:6] !== 32'h0000_BEEF) begin bad++; $display("FAIL hold_take got=%h exp=0000beef", ME_to_WB_Bus[37:6]); end
        total++; if (ME_Allow_in !== 1'b1) begin bad++; $display("FAIL hold_allow_take got=%b exp=1", ME_Allow_in); end
        step();
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL hold_drain got=%b exp=0", ME_to_WB_Valid); end
        step();
    endtask

    task automatic test_flush_cancel();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 0, 0, 0, 0, 5'b00000, 32'h300, 32'h0, 1, 1, 5'd3);
        step();
        EX_to_ME_Valid = 1'b0;
        excp_flush     = 1'b1;
        step();
        excp_flush     = 1'b0;
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 0, 0, 0, 0, 5'b00000, 32'h304, 32'h0, 1, 1, 5'd4);
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0 || ME_dest !== 5'd0) begin bad++; $display("FAIL flush_kill got=%b/%0d exp=0/0", ME_to_WB_Valid, ME_dest); end
        total++; if (ME_Allow_in !== 1'b1) begin bad++; $display("FAIL flush_allow got=%b exp=1", ME_Allow_in); end
        step();
        EX_to_ME_Valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_AAAA;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL flush_swallow got=%b exp=0", ME_to_WB_Valid); end
        step();
        data_sram_data_ok = 1'b0;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL flush_gap got=%b exp=0", ME_to_WB_Valid); end
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_BBBB;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b1 || ME_to_WB_Bus[37:6] !== 32'h0000_BBBB) begin
            bad++; $display("FAIL flush_second got=%b/%h exp=1/0000bbbb", ME_to_WB_Valid, ME_to_WB_Bus[37:6]); end
        step();
        data_sram_data_ok = 1'b0;
        step();
    endtask

    task automatic test_excp();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(1, 6'b100000, 14'h0, 1, 32'h77, 0, 5'b00000, 32'h400, 32'h0, 1, 1, 5'd2);
        step();
        EX_to_ME_Valid = 1'b0;
        WB_Allow_in    = 1'b0;
        #2;
        total++; if (ME_to_WB_Valid !== 1'b1) begin bad++; $display("FAIL excp_ready got=%b exp=1", ME_to_WB_Valid); end
        total++; if (ME_to_EX_Sys_op !== 1'b1) begin bad++; $display("FAIL excp_sysop got=%b exp=1", ME_to_EX_Sys_op); end
        total++; if (ME_to_EX_Bus[32] !== 1'b0) begin bad++; $display("FAIL excp_csr_we got=%b exp=0", ME_to_EX_Bus[32]); end
        total++; if (ME_to_WB_Bus[124:118] !== 7'b1100000) begin bad++; $display("FAIL excp_fields got=%b exp=1100000", ME_to_WB_Bus[124:118]); end
        WB_Allow_in = 1'b1;
        step();
        step();
    endtask

    task automatic test_csr();
        EX_to_ME_Valid = 1'b1;
        EX_to_ME_Bus   = mk_bus(0, 0, 14'h6, 1, 32'h55, 0, 5'b00000, 32'h500, 32'h0, 0, 0, 5'd0);
        step();
        EX_to_ME_Valid = 1'b0;
        WB_Allow_in    = 1'b0;
        #2;
        total++; if (ME_to_EX_Bus !== {14'h6, 1'b1, 32'h55}) begin bad++; $display("FAIL csr_bus got=%h exp=%h", ME_to_EX_Bus, {14'h6, 1'b1, 32'h55}); end
        total++; if (ME_to_EX_Sys_op !== 1'b0) begin bad++; $display("FAIL csr_sysop got=%b exp=0", ME_to_EX_Sys_op); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        WB_Allow_in = 1'b1;
        #2;
        total++; if (ME_to_EX_Bus[32] !== 1'b0) begin bad++; $display("FAIL csr_after_reset got=%b exp=0", ME_to_EX_Bus[32]); end
        total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL csr_reset_valid got=%b exp=0", ME_to_WB_Valid); end
        step();
    endtask

    typedef struct {
        logic [31:0] res;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        gw;
        logic        ld;
    } exp_t;

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic        pend = 1'b0;
        int          dly = 0;
        logic [31:0] pdata = 32'h0;
        logic        ld, gw, sgn;
        logic [1:0]  off;
        logic [4:0]  flag, dest;
        logic [31:0] res, pc, ldata;
        int          kind, drain;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            WB_Allow_in    = ($urandom % 4) != 0;
            EX_to_ME_Valid = ($urandom % 10) < 7;
            ld    = 1'($urandom % 2);
            kind  = int'($urandom % 3);
            sgn   = 1'($urandom % 2);
            off   = 2'($urandom % 4);
            flag  = {sgn, kind == 0, kind == 1, off};
            res   = $urandom;
            pc    = $urandom;
            dest  = 5'($urandom % 32);
            gw    = 1'($urandom % 2);
            ldata = $urandom;
            EX_to_ME_Bus = mk_bus(0, 0, 0, 0, 0, 0, flag, pc, res, ld, gw, dest);
            if (pend && dly == 0) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = pdata;
            end else begin
                data_sram_data_ok = 1'b0;
                data_sram_rdata   = $urandom;
            end
            #2;
            if (pend && !data_sram_data_ok) begin
                total++; if (ME_to_WB_Valid !== 1'b0) begin bad++; $display("FAIL rnd_early cyc=%0d got=%b exp=0", cyc, ME_to_WB_Valid); end
            end
            if (ME_to_WB_Valid && WB_Allow_in) begin
                if (q.size() == 0) begin
                    total++; bad++; $display("FAIL rnd_spurious cyc=%0d got=valid exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    total++; if (ME_to_WB_Bus[37:6] !== e.res || ME_to_WB_Bus[69:38] !== e.pc) begin
                        bad++; $display("FAIL rnd_result cyc=%0d got=%h/%h exp=%h/%h", cyc, ME_to_WB_Bus[37:6], ME_to_WB_Bus[69:38], e.res, e.pc); end
                    total++; if (ME_dest !== (e.gw ? e.dest : 5'd0)) begin
                        bad++; $display("FAIL rnd_dest cyc=%0d got=%0d exp=%0d", cyc, ME_dest, e.gw ? e.dest : 5'd0); end
                    if (!e.ld) begin
                        total++; if (ME_Forward_Res !== e.res) begin bad++; $display("FAIL rnd_fwd cyc=%0d got=%h exp=%h", cyc, ME_Forward_Res, e.res); end
                    end
                end
            end
            if (data_sram_data_ok) pend = 1'b0;
            if (pend && dly > 0) dly--;
            if (ME_Allow_in && EX_to_ME_Valid) begin
                e.res  = ld ? align_ref(ldata, flag) : res;
                e.pc   = pc;
                e.dest = dest;
                e.gw   = gw;
                e.ld   = ld;
                q.push_back(e);
                if (ld) begin
                    pend  = 1'b1;
                    dly   = int'($urandom_range(2, 0));
                    pdata = ldata;
                end
            end
            step();
        end
        EX_to_ME_Valid = 1'b0;
        WB_Allow_in    = 1'b1;
        drain = 0;
        while (q.size() != 0 && drain < 20) begin
            data_sram_data_ok = pend;
            data_sram_rdata   = pdata;
            #2;
            if (ME_to_WB_Valid) begin
                e = q.pop_front();
                total++; if (ME_to_WB_Bus[37:6] !== e.res) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", ME_to_WB_Bus[37:6], e.res); end
            end
            if (data_sram_data_ok) pend = 1'b0;
            drain++;
            step();
        end
        data_sram_data_ok = 1'b0;
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_leftover got=%0d exp=0", q.size()); end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_load_hold();
        test_flush_cancel();
        test_excp();
        test_csr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
